// File: rtl/alu_pkg.sv
// alu_pkg: shared operation and serial-controller state encodings.
// Ports: none (package).
package alu_pkg;
    typedef enum logic [0:0] {OP_ADD, OP_SUB} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} ser_state_e;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell.
// Ports: a, b, cin (in, 1 bit); s sum, cout carry (out, 1 bit).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract over one full_adder, LSB first, WIDTH cycles per op.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op, a, b operand handshake;
//        out_valid/out_ready, result, cout, overflow result handshake.
module serial_addsub_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_MSB = CW'(WIDTH - 2);

    ser_state_e state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sa, sb;
    logic carry, carry_msb, fa_s, fa_cout;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    // The sum is shifted in at the MSB so bit 0 lands in result[0] after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            sa    <= a;
            sb    <= (op == OP_SUB) ? ~b : b;
            carry <= op;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            result <= {fa_s, result[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            if (cnt == PRE_MSB) carry_msb <= fa_cout;
            if (cnt == LAST) begin
                cout     <= fa_cout;
                overflow <= carry_msb ^ fa_cout;
            end
        end
endmodule
